// File: rtl/fwrisc_exec_formal_pkg.sv
// Shared types and constants for the exec-unit formal/sim stimulus harness.
// Used by the driver, its memory responder and the smoke checker.
package fwrisc_exec_formal_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_GAP
  } iss_state_e;

  typedef enum logic {
    MIDLE,
    MWAIT
  } mem_state_e;

  localparam logic [4:0] OP_TYPE_ARITH   = 5'd0;
  localparam logic [4:0] OP_TYPE_LOGICAL = 5'd1;
  localparam logic [4:0] OP_TYPE_SHIFT   = 5'd2;
  localparam logic [4:0] OP_TYPE_BRANCH  = 5'd3;
  localparam logic [4:0] OP_TYPE_LDST    = 5'd4;

  localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/fwrisc_exec_mem_responder.sv
// Word-addressed data memory answering the exec dvalid/dready bus
// with a fixed latency and byte-strobed stores.
module fwrisc_exec_mem_responder
  import fwrisc_exec_formal_pkg::*;
#(
  parameter int MEM_AW      = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic        dvalid,
  input  logic        dwrite,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        proto_err
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0]       mem_q [DEPTH];
  mem_state_e        state_q;
  logic [MEM_AW-1:0] idx_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        stb_q;
  logic [3:0]        lat_q;
  logic [31:0]       rdata_q;
  logic              perr_q;
  logic              resp;
  logic              unused_addr;

  assign unused_addr = ^{daddr[31:MEM_AW+2], daddr[1:0]};

  assign resp      = (state_q == MWAIT) && (lat_q == 4'd0);
  assign dready    = resp && !reset;
  assign proto_err = perr_q;

  // Load data is visible in the response cycle itself, then held.
  always_comb begin
    drdata = rdata_q;
    if (reset)
      drdata = '0;
    else if (resp && !wr_q)
      drdata = mem_q[idx_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MIDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      stb_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      unique case (state_q)
        MIDLE: begin
          if (dvalid) begin
            idx_q   <= daddr[MEM_AW+1:2];
            wr_q    <= dwrite;
            wdata_q <= dwdata;
            stb_q   <= dwstb;
            lat_q   <= 4'(MEM_LATENCY);
            state_q <= MWAIT;
          end
        end
        MWAIT: begin
          if (resp) begin
            state_q <= MIDLE;
            if (wr_q) begin
              for (int b = 0; b < 4; b++)
                if (stb_q[b])
                  mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end else begin
              rdata_q <= mem_q[idx_q];
            end
          end else begin
            lat_q <= lat_q - 4'd1;
            if (!dvalid)
              perr_q <= 1'b1;
          end
        end
        default: state_q <= MIDLE;
      endcase
    end
  end

endmodule

// File: rtl/fwrisc_exec_formal_driver.sv
// Issues one instruction at a time to the exec unit and waits for
// instr_complete; also hosts the data memory responder.
module fwrisc_exec_formal_driver
  import fwrisc_exec_formal_pkg::*;
#(
  parameter int MEM_AW      = 4,
  parameter int MEM_LATENCY = 1,
  parameter int GAP_CYCLES  = 0,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op_type,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  input  logic [5:0]  cmd_op,
  input  logic [31:0] cmd_op_c,
  input  logic        cmd_instr_c,
  output logic        decode_valid,
  output logic [4:0]  op_type,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [5:0]  op,
  output logic [31:0] op_c,
  output logic        instr_c,
  input  logic        instr_complete,
  input  logic [31:0] daddr,
  input  logic        dvalid,
  input  logic        dwrite,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  output logic [31:0] drdata,
  output logic        dready,
  output logic [7:0]  instr_count,
  output logic        timeout_err,
  output logic        proto_err
);

  iss_state_e  state_q;
  logic [7:0]  wait_q;
  logic [3:0]  gap_q;
  logic [7:0]  cnt_q;
  logic        dv_q;
  logic        tmo_q;
  logic        perr_q;
  logic        mem_perr;

  assign cmd_ready    = (state_q == S_IDLE) && !reset;
  assign decode_valid = dv_q;
  assign instr_count  = cnt_q;
  assign timeout_err  = tmo_q;
  assign proto_err    = perr_q | mem_perr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      tmo_q   <= 1'b0;
      perr_q  <= 1'b0;
      op_type <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op      <= '0;
      op_c    <= '0;
      instr_c <= 1'b0;
    end else begin
      if (instr_complete && state_q != S_BUSY)
        perr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_type <= cmd_op_type;
            op_a    <= cmd_op_a;
            op_b    <= cmd_op_b;
            op      <= cmd_op;
            op_c    <= cmd_op_c;
            instr_c <= cmd_instr_c;
            dv_q    <= 1'b1;
            wait_q  <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (instr_complete) begin
            dv_q   <= 1'b0;
            wait_q <= '0;
            if (cnt_q != 8'hFF)
              cnt_q <= cnt_q + 8'd1;
            gap_q   <= 4'(GAP_CYCLES - 1);
            state_q <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else if (wait_q == 8'(TIMEOUT - 1)) begin
            tmo_q   <= 1'b1;
            dv_q    <= 1'b0;
            wait_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_q == 4'd0)
            state_q <= S_IDLE;
          else
            gap_q <= gap_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fwrisc_exec_mem_responder #(
    .MEM_AW      (MEM_AW),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .daddr     (daddr),
    .dvalid    (dvalid),
    .dwrite    (dwrite),
    .dwdata    (dwdata),
    .dwstb     (dwstb),
    .drdata    (drdata),
    .dready    (dready),
    .proto_err (mem_perr)
  );

endmodule

// File: tb/tb_fwrisc_exec_formal_driver.sv
// Directed plus randomized bench for the exec formal driver, checked
// against a transaction-level model of issue timing and data memory.
module tb_fwrisc_exec_formal_driver;
  import fwrisc_exec_formal_pkg::*;

  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int GAP = 3;
  localparam int TMO = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op_type = '0;
  logic [31:0] cmd_op_a = '0;
  logic [31:0] cmd_op_b = '0;
  logic [5:0]  cmd_op = '0;
  logic [31:0] cmd_op_c = '0;
  logic        cmd_instr_c = 1'b0;
  logic        decode_valid;
  logic [4:0]  op_type;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  op;
  logic [31:0] op_c;
  logic        instr_c;
  logic        instr_complete = 1'b0;
  logic [31:0] daddr = '0;
  logic        dvalid = 1'b0;
  logic        dwrite = 1'b0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwstb = '0;
  logic [31:0] drdata;
  logic        dready;
  logic [7:0]  instr_count;
  logic        timeout_err;
  logic        proto_err;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] mdl_mem [16];
  logic [31:0] last_rd;
  int          exp_cnt;
  logic        exp_tmo;
  logic        exp_proto;

  fwrisc_exec_formal_driver #(
    .MEM_AW      (AW),
    .MEM_LATENCY (LAT),
    .GAP_CYCLES  (GAP),
    .TIMEOUT     (TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op_type    (cmd_op_type),
    .cmd_op_a       (cmd_op_a),
    .cmd_op_b       (cmd_op_b),
    .cmd_op         (cmd_op),
    .cmd_op_c       (cmd_op_c),
    .cmd_instr_c    (cmd_instr_c),
    .decode_valid   (decode_valid),
    .op_type        (op_type),
    .op_a           (op_a),
    .op_b           (op_b),
    .op             (op),
    .op_c           (op_c),
    .instr_c        (instr_c),
    .instr_complete (instr_complete),
    .daddr          (daddr),
    .dvalid         (dvalid),
    .dwrite         (dwrite),
    .dwdata         (dwdata),
    .dwstb          (dwstb),
    .drdata         (drdata),
    .dready         (dready),
    .instr_count    (instr_count),
    .timeout_err    (timeout_err),
    .proto_err      (proto_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    last_rd   = '0;
    exp_cnt   = 0;
    exp_tmo   = 1'b0;
    exp_proto = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    instr_complete = 1'b0;
    dvalid = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (decode_valid !== 1'b0) begin
      n_err++; $error("FAIL rst_dv %0h", decode_valid);
    end
    n_checks++;
    if (dready !== 1'b0) begin
      n_err++; $error("FAIL rst_dready %0h", dready);
    end
    n_checks++;
    if (instr_count !== 8'd0) begin
      n_err++; $error("FAIL rst_cnt %0h", instr_count);
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_err++; $error("FAIL rst_tmo %0h", timeout_err);
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_err++; $error("FAIL rst_proto %0h", proto_err);
    end
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $error("FAIL rst_cmd_ready %0h", cmd_ready);
    end
    n_checks++;
    if (drdata !== 32'd0) begin
      n_err++; $error("FAIL rst_drdata %0h", drdata);
    end
    n_checks++;
    if (op_a !== 32'd0) begin
      n_err++; $error("FAIL rst_opa %0h", op_a);
    end
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $error("FAIL post_rst_ready %0h", cmd_ready);
    end
  endtask

  task automatic issue(input logic [4:0] t, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] o,
                       input logic [31:0] c, input logic ic, input int d,
                       output int t_rise, output int t_comp);
    int n;
    logic [107:0] obs;
    logic [107:0] expv;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $error("FAIL cmd_ready %0h", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op_type = t; cmd_op_a = a; cmd_op_b = b;
    cmd_op = o; cmd_op_c = c; cmd_instr_c = ic;
    @(negedge clock);
    cmd_valid = 1'b0;
    t_rise = cyc;
    expv = {t, a, b, o, c, ic};
    obs = {op_type, op_a, op_b, op, op_c, instr_c};
    n_checks++;
    if (decode_valid !== 1'b1) begin
      n_err++; $error("FAIL dv_rise %0h", decode_valid);
    end
    n_checks++;
    if (obs !== expv) begin
      n_err++; $error("FAIL fields %0h %0h", obs, expv);
    end
    cmd_op_a = $urandom(); cmd_op_b = $urandom(); cmd_op_c = $urandom();
    repeat (d - 1) @(negedge clock);
    obs = {op_type, op_a, op_b, op, op_c, instr_c};
    n_checks++;
    if (decode_valid !== 1'b1) begin
      n_err++; $error("FAIL dv_hold %0h", decode_valid);
    end
    n_checks++;
    if (obs !== expv) begin
      n_err++; $error("FAIL fields_hold %0h %0h", obs, expv);
    end
    instr_complete = 1'b1;
    t_comp = cyc;
    @(negedge clock);
    instr_complete = 1'b0;
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    n_checks++;
    if (decode_valid !== 1'b0) begin
      n_err++; $error("FAIL dv_fall %0h", decode_valid);
    end
    n_checks++;
    if (instr_count !== 8'(exp_cnt)) begin
      n_err++; $error("FAIL count %0h %0h", instr_count, exp_cnt);
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (n != GAP) begin
      n_err++; $error("FAIL gap_len %0d", n);
    end
    n_checks++;
    if (timeout_err !== exp_tmo) begin
      n_err++; $error("FAIL tmo_flag %0h", timeout_err);
    end
  endtask

  task automatic mem_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] stb,
                          output logic [31:0] rd);
    int n;
    int idx;
    idx = int'(addr[5:2]);
    dvalid = 1'b1; dwrite = wr; daddr = addr; dwdata = wd; dwstb = stb;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (dready !== 1'b1 && n < 40);
    n_checks++;
    if (n != LAT + 1) begin
      n_err++; $error("FAIL mem_lat %0d", n);
    end
    rd = drdata;
    if (wr) begin
      n_checks++;
      if (drdata !== last_rd) begin
        n_err++; $error("FAIL st_drdata_hold %0h %0h", drdata, last_rd);
      end
      for (int bl = 0; bl < 4; bl++)
        if (stb[bl]) mdl_mem[idx][8*bl +: 8] = wd[8*bl +: 8];
    end else begin
      n_checks++;
      if (drdata !== mdl_mem[idx]) begin
        n_err++; $error("FAIL ld_data %0h %0h", drdata, mdl_mem[idx]);
      end
      last_rd = mdl_mem[idx];
    end
    dvalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (dready !== 1'b0) begin
      n_err++; $error("FAIL dready_pulse %0h", dready);
    end
    n_checks++;
    if (proto_err !== exp_proto) begin
      n_err++; $error("FAIL mem_proto %0h", proto_err);
    end
  endtask

  initial begin : main
    int tr1, tc1, tr2, tc2, n;
    logic [31:0] rd;
    model_clear();
    do_reset();

    issue(OP_TYPE_ARITH, 32'h5, 32'h3, 6'd0, 32'd0, 1'b0, 3, tr1, tc1);
    n_checks++;
    if (instr_count !== 8'd1) begin
      n_err++; $error("FAIL first_count %0h", instr_count);
    end
    issue(OP_TYPE_LOGICAL, 32'h11, 32'h22, 6'd7, 32'h33, 1'b1, 2, tr2, tc2);
    n_checks++;
    if (tr2 - tc1 != GAP + 2) begin
      n_err++; $error("FAIL issue_spacing %0d", tr2 - tc1);
    end

    mem_xfer(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd);
    mem_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'h00BB00DD) begin
      n_err++; $error("FAIL strobe_word %0h", rd);
    end
    mem_xfer(1'b0, 32'hFFFF_FF8B, 32'h0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'h00BB00DD) begin
      n_err++; $error("FAIL alias_word %0h", rd);
    end

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        issue(5'($urandom()), $urandom(), $urandom(), 6'($urandom()),
              $urandom(), 1'($urandom()), int'($urandom_range(10, 1)),
              tr1, tc1);
      end else begin
        mem_xfer(1'($urandom()), $urandom(), $urandom(),
                 4'($urandom()), rd);
      end
    end

    for (int i = 0; i < 260; i++)
      issue(OP_TYPE_SHIFT, i, ~i, 6'd1, 32'd0, 1'b0, 1, tr1, tc1);
    n_checks++;
    if (instr_count !== 8'hFF) begin
      n_err++; $error("FAIL count_sat %0h", instr_count);
    end

    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 0;
    while (decode_valid === 1'b1 && n < 300) begin
      n++;
      @(negedge clock);
    end
    exp_tmo = 1'b1;
    n_checks++;
    if (n != TMO) begin
      n_err++; $error("FAIL tmo_cycles %0d", n);
    end
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_err++; $error("FAIL tmo_set %0h", timeout_err);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $error("FAIL tmo_idle %0h", cmd_ready);
    end
    issue(OP_TYPE_BRANCH, 32'h1, 32'h2, 6'd3, 32'h4, 1'b0, 4, tr1, tc1);
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_err++; $error("FAIL tmo_sticky %0h", timeout_err);
    end

    n_checks++;
    if (proto_err !== 1'b0) begin
      n_err++; $error("FAIL proto_clean %0h", proto_err);
    end
    instr_complete = 1'b1;
    @(negedge clock);
    instr_complete = 1'b0;
    @(negedge clock);
    exp_proto = 1'b1;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_err++; $error("FAIL proto_idle %0h", proto_err);
    end
    n_checks++;
    if (instr_count !== 8'(exp_cnt)) begin
      n_err++; $error("FAIL proto_cnt %0h", instr_count);
    end

    do_reset();
    dvalid = 1'b1; dwrite = 1'b0; daddr = 32'h4;
    @(negedge clock);
    dvalid = 1'b0;
    n = 0;
    while (dready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (dready !== 1'b1) begin
      n_err++; $error("FAIL drop_done %0h", dready);
    end
    @(negedge clock);
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_err++; $error("FAIL drop_proto %0h", proto_err);
    end

    do_reset();
    mem_xfer(1'b1, 32'h14, 32'h12345678, 4'hF, rd);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    dvalid = 1'b1; dwrite = 1'b0; daddr = 32'h14;
    @(negedge clock);
    n_checks++;
    if (decode_valid !== 1'b1) begin
      n_err++; $error("FAIL mid_busy %0h", decode_valid);
    end
    reset = 1'b1;
    dvalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (dready !== 1'b0) begin
      n_err++; $error("FAIL mid_rst_dready %0h", dready);
    end
    n_checks++;
    if (decode_valid !== 1'b0) begin
      n_err++; $error("FAIL mid_rst_dv %0h", decode_valid);
    end
    n_checks++;
    if (instr_count !== 8'd0) begin
      n_err++; $error("FAIL mid_rst_cnt %0h", instr_count);
    end
    reset = 1'b0;
    model_clear();
    mem_xfer(1'b0, 32'h14, 32'h0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_err++; $error("FAIL mid_rst_mem %0h", rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
